// File: rtl/wheel_input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : wheel_input_conditioner_if
//  Description : Bundle of the raw encoder pins, the diagnostic clear and the
//                conditioned outputs of the wheel input conditioner.
//                master = the side driving the pins, slave = the conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wheel_input_conditioner_if #(
    parameter int GLITCH_W = 8
);
    logic                a_raw;
    logic                b_raw;
    logic                glitch_clr;
    logic                A;
    logic                B;
    logic                A_prev;
    logic [GLITCH_W-1:0] glitch_count;

    modport master (
        output a_raw,
        output b_raw,
        output glitch_clr,
        input  A,
        input  B,
        input  A_prev,
        input  glitch_count
    );

    modport slave (
        input  a_raw,
        input  b_raw,
        input  glitch_clr,
        output A,
        output B,
        output A_prev,
        output glitch_count
    );
endinterface
`default_nettype wire

// File: rtl/wheel_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : wheel_input_conditioner
//  Description : Front end for the wheel quadrature control unit. Each raw
//                encoder channel is brought into the clk domain through a
//                2-flop synchronizer and then debounced by a consecutive-
//                sample filter. Provides filtered A, B and a one-cycle
//                delayed A for edge/direction decode, plus a saturating
//                count of rejected glitches for diagnostics.
//  Revision    : 1.0 - initial release
// ============================================================================
module wheel_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GLITCH_W        = 8
) (
    input  wire logic                clk,
    input  wire logic                reset,
    wheel_input_conditioner_if.slave bus
);

    // Counter wide enough to hold DEBOUNCE_CYCLES-1; at least one bit so the
    // DEBOUNCE_CYCLES=1 case still elaborates to a legal vector.
    localparam int c_CNT_W = $clog2((DEBOUNCE_CYCLES < 2) ? 2 : DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W:0]  c_GLITCH_MAX = {1'b0, {GLITCH_W{1'b1}}};

    // Index 0 is channel A, index 1 is channel B.
    logic [1:0] w_raw;
    logic [1:0] w_filt;
    logic [1:0] w_glitch;

    assign w_raw = {bus.b_raw, bus.a_raw};

    // ------------------------------------------------------------------------
    // Per-channel synchronizer and debounce filter. The two channels share no
    // state, so simultaneous transitions are judged independently.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic               r_s1;
        logic               r_s2;
        logic               r_filt;
        logic [c_CNT_W-1:0] r_cnt;

        // Two-flop synchronizer; the raw pin feeds nothing but r_s1.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
            end else begin
                r_s1 <= w_raw[gi];
                r_s2 <= r_s1;
            end
        end

        // Debounce: accept s2 once it has differed from the filtered level
        // for DEBOUNCE_CYCLES consecutive edges; an early return is a glitch.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_filt <= 1'b0;
                r_cnt  <= '0;
            end else if (r_s2 != r_filt) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_filt <= r_s2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (r_cnt != '0) begin
                r_cnt <= '0;
            end
        end

        // A pending transition abandoned this cycle counts as one glitch.
        assign w_glitch[gi] = (r_s2 == r_filt) && (r_cnt != '0);
        assign w_filt[gi]   = r_filt;
    end

    // ------------------------------------------------------------------------
    // Glitch diagnostics: add 0..2 events per cycle, clamp at all-ones.
    // ------------------------------------------------------------------------
    logic [GLITCH_W-1:0] r_glitch_count;
    logic [GLITCH_W:0]   w_glitch_sum;

    // One spare bit so a +2 from max-1 is visible before clamping.
    assign w_glitch_sum = {1'b0, r_glitch_count}
                        + {{GLITCH_W{1'b0}}, w_glitch[0]}
                        + {{GLITCH_W{1'b0}}, w_glitch[1]};

    // Saturating counter; a clear in the same cycle as an event wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_glitch_count <= '0;
        end else if (bus.glitch_clr) begin
            r_glitch_count <= '0;
        end else if (w_glitch_sum > c_GLITCH_MAX) begin
            r_glitch_count <= '1;
        end else begin
            r_glitch_count <= w_glitch_sum[GLITCH_W-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Previous-cycle copy of filtered A for rising/falling edge detection.
    // ------------------------------------------------------------------------
    logic r_a_prev;

    // A_prev trails A by exactly one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_prev <= 1'b0;
        end else begin
            r_a_prev <= w_filt[0];
        end
    end

    // All outputs come straight from flops.
    assign bus.A            = w_filt[0];
    assign bus.B            = w_filt[1];
    assign bus.A_prev       = r_a_prev;
    assign bus.glitch_count = r_glitch_count;

endmodule
`default_nettype wire

// File: tb/tb_wheel_input_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wheel_input_conditioner
//  Description : Directed, table-driven bench for wheel_input_conditioner.
//                dut0: DEBOUNCE_CYCLES=4, GLITCH_W=8. dut1: DEBOUNCE_CYCLES=4,
//                GLITCH_W=2 for saturation and clear-priority cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wheel_input_conditioner;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    wheel_input_conditioner_if #(.GLITCH_W(8)) bus0 ();
    wheel_input_conditioner_if #(.GLITCH_W(2)) bus1 ();

    wheel_input_conditioner #(.DEBOUNCE_CYCLES(4), .GLITCH_W(8)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    wheel_input_conditioner #(.DEBOUNCE_CYCLES(4), .GLITCH_W(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       a;
        logic       b;
        logic       clr;
        int         cycles;
        logic       exp_a;
        logic       exp_b;
        logic       exp_ap;
        logic [7:0] exp_gc;
    } vec_t;

    localparam int N_VEC = 16;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges and settle 1ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic a, input logic b, input logic clr, input int cyc,
                                input logic ea, input logic eb, input logic eap, input logic [7:0] egc);
        vec_t v;
        v.a = a; v.b = b; v.clr = clr; v.cycles = cyc;
        v.exp_a = ea; v.exp_b = eb; v.exp_ap = eap; v.exp_gc = egc;
        return v;
    endfunction

    // dut1 single-edge pulse on chosen channels; the glitch event lands on
    // the third edge after the pulse edge.
    task automatic pulse1(input logic on_a, input logic on_b);
        bus1.a_raw = on_a;
        bus1.b_raw = on_b;
        tick(1);
        bus1.a_raw = 1'b0;
        bus1.b_raw = 1'b0;
        tick(3);
    endtask

    int  rise_b0;
    int  rise_b1;
    logic ea;
    logic eb;

    initial begin
        reset = 1'b1;
        bus0.a_raw = 1'b0; bus0.b_raw = 1'b0; bus0.glitch_clr = 1'b0;
        bus1.a_raw = 1'b0; bus1.b_raw = 1'b0; bus1.glitch_clr = 1'b0;

        // Table: edges counted from the first edge after reset release.
        vecs[0]  = mk(0, 0, 0, 9,  0, 0, 0, 8'd0);  // idle through edge 9
        vecs[1]  = mk(1, 0, 0, 5,  0, 0, 0, 8'd0);  // a_raw high before edge 10; A still 0 at 14
        vecs[2]  = mk(1, 0, 0, 1,  1, 0, 0, 8'd0);  // edge 15: A=1, A_prev=0
        vecs[3]  = mk(1, 0, 0, 1,  1, 0, 1, 8'd0);  // edge 16: A_prev=1
        vecs[4]  = mk(1, 0, 0, 10, 1, 0, 1, 8'd0);  // settle
        vecs[5]  = mk(0, 0, 0, 3,  1, 0, 1, 8'd0);  // 3-edge low pulse on A
        vecs[6]  = mk(1, 0, 0, 2,  1, 0, 1, 8'd0);  // cnt at 3, no event yet
        vecs[7]  = mk(1, 0, 0, 1,  1, 0, 1, 8'd1);  // s2 back high: glitch
        vecs[8]  = mk(0, 0, 0, 5,  1, 0, 1, 8'd1);  // clean fall, still pending
        vecs[9]  = mk(0, 0, 0, 1,  0, 0, 1, 8'd1);  // A falls
        vecs[10] = mk(0, 0, 0, 1,  0, 0, 0, 8'd1);  // A_prev follows
        vecs[11] = mk(1, 1, 0, 2,  0, 0, 0, 8'd1);  // simultaneous 2-edge pulses
        vecs[12] = mk(0, 0, 0, 2,  0, 0, 0, 8'd1);
        vecs[13] = mk(0, 0, 0, 1,  0, 0, 0, 8'd3);  // +2 in one cycle
        vecs[14] = mk(0, 0, 1, 1,  0, 0, 0, 8'd0);  // clear
        vecs[15] = mk(0, 0, 0, 3,  0, 0, 0, 8'd0);

        // Reset state.
        tick(3);
        check("reset A", bus0.A, 1'b0);
        check("reset B", bus0.B, 1'b0);
        check("reset A_prev", bus0.A_prev, 1'b0);
        check("reset gc0", bus0.glitch_count, 8'd0);
        check("reset gc1", bus1.glitch_count, 2'd0);
        reset = 1'b0;

        // Table-driven section on dut0.
        for (int i = 0; i < N_VEC; i++) begin
            bus0.a_raw      = vecs[i].a;
            bus0.b_raw      = vecs[i].b;
            bus0.glitch_clr = vecs[i].clr;
            tick(vecs[i].cycles);
            bus0.glitch_clr = 1'b0;
            check($sformatf("row%0d A", i), bus0.A, vecs[i].exp_a);
            check($sformatf("row%0d B", i), bus0.B, vecs[i].exp_b);
            check($sformatf("row%0d A_prev", i), bus0.A_prev, vecs[i].exp_ap);
            check($sformatf("row%0d gc", i), bus0.glitch_count, vecs[i].exp_gc);
        end

        // Full CW quadrature sequence, 20 edges per phase; outputs must be
        // the raw pattern delayed 5 edges (2 sync + 4 filter - 1 shared edge).
        rise_b0 = 0;
        rise_b1 = 0;
        for (int j = 0; j < 90; j++) begin
            bus0.a_raw = (j < 40);
            bus0.b_raw = (j >= 20) && (j < 60);
            tick(1);
            ea = (j >= 5) && ((j - 5) < 40);
            eb = (j >= 25) && ((j - 5) < 60);
            check($sformatf("cw%0d A", j), bus0.A, ea);
            check($sformatf("cw%0d B", j), bus0.B, eb);
            if (!bus0.A_prev && bus0.A && !bus0.B) rise_b0++;
            if (!bus0.A_prev && bus0.A && bus0.B) rise_b1++;
        end
        check("cw rise with B=0", rise_b0, 1);
        check("cw rise with B=1", rise_b1, 0);
        check("cw gc", bus0.glitch_count, 8'd0);

        // dut1: saturation at 3 with single-channel events.
        for (int i = 1; i <= 5; i++) begin
            bus1.a_raw = 1'b1;
            tick(1);
            bus1.a_raw = 1'b0;
            tick(2);
            check($sformatf("sat pre%0d", i), bus1.glitch_count, (i - 1 > 3) ? 3 : i - 1);
            tick(1);
            check($sformatf("sat post%0d", i), bus1.glitch_count, (i > 3) ? 3 : i);
            check($sformatf("sat A%0d", i), bus1.A, 1'b0);
            tick(1);
        end
        bus1.glitch_clr = 1'b1;
        tick(1);
        bus1.glitch_clr = 1'b0;
        check("clr", bus1.glitch_count, 2'd0);

        // +2 from max-1 lands on max.
        pulse1(1'b1, 1'b0);
        pulse1(1'b1, 1'b0);
        check("gc at max-1", bus1.glitch_count, 2'd2);
        pulse1(1'b1, 1'b1);
        check("+2 saturates", bus1.glitch_count, 2'd3);
        check("pulse B held", bus1.B, 1'b0);

        // Clear in the same cycle as a glitch event.
        bus1.a_raw = 1'b1;
        tick(1);
        bus1.a_raw = 1'b0;
        tick(2);
        bus1.glitch_clr = 1'b1;
        tick(1);
        bus1.glitch_clr = 1'b0;
        check("clr priority", bus1.glitch_count, 2'd0);
        tick(1);
        check("clr stays", bus1.glitch_count, 2'd0);
        pulse1(1'b1, 1'b0);
        check("gc before reset", bus1.glitch_count, 2'd1);

        // Reset mid-transition on dut0 with B already high.
        bus0.a_raw = 1'b0;
        bus0.b_raw = 1'b1;
        tick(8);
        check("B before reset", bus0.B, 1'b1);
        bus0.a_raw = 1'b1;
        tick(4);
        check("A pending", bus0.A, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async reset A", bus0.A, 1'b0);
        check("async reset B", bus0.B, 1'b0);
        check("async reset A_prev", bus0.A_prev, 1'b0);
        check("async reset gc1", bus1.glitch_count, 2'd0);
        tick(2);
        reset = 1'b0;
        tick(5);
        check("post-reset A early", bus0.A, 1'b0);
        check("post-reset B early", bus0.B, 1'b0);
        tick(1);
        check("post-reset A", bus0.A, 1'b1);
        check("post-reset B", bus0.B, 1'b1);
        check("post-reset A_prev", bus0.A_prev, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
